mips_cpu_instr_fetch: RTL and testbench
=======================================

// Module: mips_cpu_instr_fetch
// PURPOSE
//  Producer end of the Instr/CtrlPC interface: fetches instruction words over a memory-mapped bus, presents Instr to
//  decode/control, and consumes CtrlPC/ALUCond to compute the next PC with one MIPS branch delay slot. Owns the PC,
//  the reset vector and CPU halt detection.
// PARAMETERS
//  RESET_VECTOR  32'hBFC00000  PC of first fetch after reset
//  HALT_ADDR     32'h00000000  PC at which fetching stops and active drops
// PORTS
//  clk                input   1   clock, all state on rising edge
//  rst_n              input   1   reset, asynchronous, active-low
//  instr_address      output  32  bus word address (= current PC)
//  instr_read         output  1   bus read request
//  instr_waitrequest  input   1   bus stall; read completes on the first cycle with read=1 and waitrequest=0
//  instr_readdata     input   32  fetched word, valid on read completion
//  Instr              output  32  held instruction word to decode
//  instr_valid        output  1   Instr valid
//  instr_ready        input   1   decode/execute accepts Instr this cycle
//  instr_pc           output  32  PC of the word in Instr (link value = instr_pc+8)
//  CtrlPC             input   2   from control for the accepted Instr: 0 seq, 1 branch, 2 J/JAL, 3 JR/JALR
//  ALUCond            input   1   branch condition, sampled with CtrlPC==1
//  RegRs              input   32  rs register value, used for CtrlPC==3
//  active             output  1   high while running; low once halted
// BEHAVIOUR
//  Reset (async, rst_n=0): state=FETCH-pending, pc=RESET_VECTOR, instr_read=0, instr_valid=0, Instr=0,
//   instr_pc=0, redirect_pending=0, active=0. First cycle after release: FETCH, active=1, instr_read=1.
//  States: FETCH -> HOLD -> (FETCH | HALTED); HALTED is terminal until reset.
//  FETCH: instr_read=1, instr_address=pc, held stable while waitrequest=1. On completion: Instr<=readdata,
//   instr_pc<=pc, instr_valid<=1, instr_read<=0, go HOLD. Latency: min 2 cycles read-issue to instr_valid.
//  HOLD: Instr/instr_pc stable while instr_ready=0 (unbounded). Accept = instr_valid & instr_ready; at accept:
//   instr_valid<=0, next pc computed (below), go FETCH the cycle after, or HALTED if next pc==HALT_ADDR.
//  Next-pc on accept (seq = instr_pc+4, all adds modulo 2^32, wrap silently):
//   - redirect_pending=1 (this is the delay-slot word): next=target_q, redirect_pending<=0; CtrlPC of the
//     delay-slot word is ignored (branch in delay slot = unsupported, no redirect taken).
//   - CtrlPC==1 & ALUCond: target_q<=seq+(sext(Instr[15:0])<<2), redirect_pending<=1, next=seq.
//   - CtrlPC==1 & !ALUCond, or CtrlPC==0: next=seq.
//   - CtrlPC==2: target_q<={seq[31:28],Instr[25:0],2'b00}, redirect_pending<=1, next=seq.
//   - CtrlPC==3: target_q<=RegRs, redirect_pending<=1, next=seq.
//  Halt: checked only on the computed next pc; a redirect to HALT_ADDR halts after the delay slot is accepted.
//   HALTED: instr_read=0, instr_valid=0, active=0, instr_address=HALT_ADDR.
//  No new read is issued while instr_valid=1 (single-entry buffer; no speculative prefetch).
//  CtrlPC/ALUCond/RegRs are sampled only in the accept cycle; other cycles don't-care.
//  Unaligned target (RegRs[1:0]!=0): used as-is on instr_address; exception handling out of scope.
//  rst_n low mid-read: instr_read drops immediately (async); pending bus read is abandoned.
// TESTING
//  1 Reset release, waitrequest=0, ready=1 -> reads at BFC00000, BFC00004, BFC00008; active=1 from cycle 1.
//  2 waitrequest=1 for 3 cycles in FETCH -> address/read held; Instr valid 1 cycle after waitrequest falls.
//  3 BEQ @BFC00000 imm=0x0003 ALUCond=1 -> next fetches BFC00004 (slot) then BFC00010; ALUCond=0 -> BFC00008.
//  4 JR RegRs=0 @BFC00010 -> slot BFC00014 fetched and accepted, then active=0, instr_read stays 0.
//  5 J Instr[25:0]=0x0000040 @BFC00020 -> slot BFC00024, then B0000100; ready=0 for 5 cycles holds Instr/instr_pc.
//  6 rst_n low while read=1 & waitrequest=1 -> read=0 at once; after release refetch from BFC00000.

Source files
------------

// File: rtl/mips_cpu_instr_fetch.sv
// mips_cpu_instr_fetch: instruction fetch stage with one branch delay slot.
// Fetches words over a simple read/waitrequest bus, holds one word for
// decode, and computes the next PC from CtrlPC/ALUCond/RegRs on accept.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   instr_address/instr_read          bus request (address = current PC)
//   instr_waitrequest/instr_readdata  bus response
//   Instr/instr_valid/instr_pc        held word to decode, its PC
//   instr_ready                       decode accepts the held word
//   CtrlPC/ALUCond/RegRs              next-PC controls, sampled on accept
//   active                            high while running, low once halted
module mips_cpu_instr_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] instr_address,
    output logic        instr_read,
    input  logic        instr_waitrequest,
    input  logic [31:0] instr_readdata,
    output logic [31:0] Instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_pc,
    input  logic [1:0]  CtrlPC,
    input  logic        ALUCond,
    input  logic [31:0] RegRs,
    output logic        active
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_START  = 2'd0,
        S_FETCH  = 2'd1,
        S_HOLD   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t            state, state_d;
    logic [XLEN-1:0]   pc, pc_d;
    logic [XLEN-1:0]   target_q, target_d;
    logic              redirect_pending, redirect_d;
    logic [XLEN-1:0]   instr_d, instr_pc_d;
    logic              instr_valid_d, instr_read_d, active_d;

    logic [XLEN-1:0]   seq_pc;
    logic [XLEN-1:0]   br_offset;
    logic [XLEN-1:0]   next_pc;
    logic              accept;

    // The bus address is always the architectural PC register.
    assign instr_address = pc;

    assign accept    = instr_valid & instr_ready;
    assign seq_pc    = instr_pc + XLEN'(4);
    assign br_offset = {{14{Instr[15]}}, Instr[15:0], 2'b00};

    // Next PC and delay-slot bookkeeping for the word being accepted.
    always_comb begin
        next_pc    = seq_pc;
        target_d   = target_q;
        redirect_d = redirect_pending;
        if (redirect_pending) begin
            // Current word is the delay slot: take the stored target and
            // ignore its own control (no nested redirect).
            next_pc    = target_q;
            redirect_d = 1'b0;
        end else begin
            unique case (CtrlPC)
                2'd1: begin
                    if (ALUCond) begin
                        target_d   = seq_pc + br_offset;
                        redirect_d = 1'b1;
                    end
                end
                2'd2: begin
                    target_d   = {seq_pc[31:28], Instr[25:0], 2'b00};
                    redirect_d = 1'b1;
                end
                2'd3: begin
                    target_d   = RegRs;
                    redirect_d = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state;
        pc_d          = pc;
        instr_d       = Instr;
        instr_pc_d    = instr_pc;
        instr_valid_d = instr_valid;
        instr_read_d  = instr_read;
        active_d      = active;

        unique case (state)
            S_START: begin
                state_d      = S_FETCH;
                instr_read_d = 1'b1;
                active_d     = 1'b1;
            end
            S_FETCH: begin
                if (!instr_waitrequest) begin
                    instr_d       = instr_readdata;
                    instr_pc_d    = pc;
                    instr_valid_d = 1'b1;
                    instr_read_d  = 1'b0;
                    state_d       = S_HOLD;
                end
            end
            S_HOLD: begin
                if (accept) begin
                    instr_valid_d = 1'b0;
                    pc_d          = next_pc;
                    if (next_pc == HALT_ADDR) begin
                        state_d      = S_HALTED;
                        instr_read_d = 1'b0;
                        active_d     = 1'b0;
                    end else begin
                        state_d      = S_FETCH;
                        instr_read_d = 1'b1;
                    end
                end
            end
            S_HALTED: begin
                instr_read_d  = 1'b0;
                instr_valid_d = 1'b0;
                active_d      = 1'b0;
            end
            default: begin
                state_d = S_START;
            end
        endcase
    end

    // Redirect state only advances when a word is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q         <= '0;
            redirect_pending <= 1'b0;
        end else if (state == S_HOLD && accept) begin
            target_q         <= target_d;
            redirect_pending <= redirect_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_START;
            pc          <= RESET_VECTOR;
            Instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            instr_read  <= 1'b0;
            active      <= 1'b0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            Instr       <= instr_d;
            instr_pc    <= instr_pc_d;
            instr_valid <= instr_valid_d;
            instr_read  <= instr_read_d;
            active      <= active_d;
        end
    end

endmodule

// File: tb/tb_mips_cpu_instr_fetch.sv
// Bench for mips_cpu_instr_fetch: a driver plays memory and decode, a
// reference model predicts the fetch stream, and a monitor checks the DUT.
module tb_mips_cpu_instr_fetch;

    localparam logic [31:0] RV     = 32'hBFC00000;
    localparam logic [31:0] HA     = 32'h00000000;
    localparam int          BUDGET = 30000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_address;
    logic        instr_read;
    logic        waitreq;
    logic [31:0] readdata;
    logic [31:0] Instr;
    logic        instr_valid;
    logic        ready;
    logic [31:0] instr_pc;
    logic [1:0]  ctrl;
    logic        cond;
    logic [31:0] rs;
    logic        active;

    mips_cpu_instr_fetch dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .instr_address     (instr_address),
        .instr_read        (instr_read),
        .instr_waitrequest (waitreq),
        .instr_readdata    (readdata),
        .Instr             (Instr),
        .instr_valid       (instr_valid),
        .instr_ready       (ready),
        .instr_pc          (instr_pc),
        .CtrlPC            (ctrl),
        .ALUCond           (cond),
        .RegRs             (rs),
        .active            (active)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_acc = 0;

    // Reference model: program counter, held word, pending redirect.
    logic [31:0] m_pc, m_word, m_tgt;
    logic        m_redir, m_halted;
    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_instr_q[$];

    int   prog;
    bit   rnd_mode;
    bit   force_wait;
    logic dir_cond;
    int   hold_cnt, wait_cnt;

    // Memory contents: directed programs or a hash for random runs.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (prog == 0) return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
        if (a == 32'hBFC00000) return 32'h10000003;            // BEQ +3
        if (prog == 1 && a == 32'hBFC00010) return 32'h00000008; // JR
        if (prog == 2 && a == 32'hBFC00020) return 32'h08000040; // J
        if (prog == 2 && a == 32'hB0000100) return 32'h00000008; // JR
        return 32'h00000000;
    endfunction

    // Decode of the few opcodes the directed programs use.
    function automatic logic [1:0] ctrl_of(input logic [31:0] w);
        if (w[31:26] == 6'h04) return 2'd1;
        if (w[31:26] == 6'h02 || w[31:26] == 6'h03) return 2'd2;
        if (w[31:26] == 6'h00 && (w[5:0] == 6'h08 || w[5:0] == 6'h09)) return 2'd3;
        return 2'd0;
    endfunction

    task automatic model_accept(input logic [1:0] c, input logic bc, input logic [31:0] r);
        logic [31:0] seq, nxt;
        int off;
        seq = m_pc + 32'd4;
        nxt = seq;
        if (m_redir) begin
            nxt     = m_tgt;
            m_redir = 1'b0;
        end else if (c == 2'd1 && bc) begin
            off     = int'($signed(m_word[15:0]));
            m_tgt   = seq + 32'(off * 4);
            m_redir = 1'b1;
        end else if (c == 2'd2) begin
            m_tgt   = (seq & 32'hF0000000) | ((m_word & 32'h03FFFFFF) << 2);
            m_redir = 1'b1;
        end else if (c == 2'd3) begin
            m_tgt   = r;
            m_redir = 1'b1;
        end
        n_acc++;
        if (nxt == HA) m_halted = 1'b1;
        else begin
            m_pc = nxt;
            exp_addr_q.push_back(nxt);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_addr_q.delete();
        exp_instr_q.delete();
        m_pc = RV; m_word = '0; m_tgt = '0; m_redir = 1'b0; m_halted = 1'b0;
        exp_addr_q.push_back(RV);
        hold_cnt = 0; wait_cnt = 0; n_acc = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One cycle of memory + decode behaviour, inputs driven after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc > BUDGET) begin
            $display("FAIL timeout: cycle=%0d budget=%0d", cyc, BUDGET);
            $fatal(1, "cycle budget exhausted");
        end
        if (force_wait) waitreq = 1'b1;
        else if (rnd_mode) waitreq = ($urandom_range(0, 2) == 0);
        else if (prog == 2 && instr_read && m_pc == 32'hBFC00008 && wait_cnt < 3) begin
            waitreq = 1'b1;
            wait_cnt++;
        end else waitreq = 1'b0;
        readdata = mem_rd(instr_address);
        if (instr_read && !waitreq) begin
            m_word = mem_rd(m_pc);
            exp_instr_q.push_back({m_word, m_pc});
        end
        ready = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (!rnd_mode && prog == 2 && instr_valid && m_pc == 32'hBFC00020 && hold_cnt < 5) begin
            ready = 1'b0;
            hold_cnt++;
        end
        ctrl = 2'($urandom_range(0, 3));
        cond = 1'($urandom_range(0, 1));
        rs   = $urandom;
        if (instr_valid && ready && !m_halted) begin
            if (!rnd_mode) begin
                ctrl = ctrl_of(m_word);
                cond = dir_cond;
                rs   = 32'h0;
            end else if ($urandom_range(0, 7) != 0) begin
                rs[1:0] = 2'b00;
            end
            model_accept(ctrl, cond, rs);
        end
    endtask

    task automatic run_to_halt();
        while (!m_halted) step();
    endtask

    // Monitor: all comparisons happen here, on the falling edge.
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic        vprev, cprev, rwprev, hprev;
    logic [31:0] aprev, held_i, held_pc;
    logic [63:0] e;

    initial begin
        vprev = 1'b0; cprev = 1'b0; rwprev = 1'b0; hprev = 1'b0;
        aprev = '0; held_i = '0; held_pc = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_read", 32'(instr_read), 32'd0);
                chk("rst_valid", 32'(instr_valid), 32'd0);
                chk("rst_active", 32'(active), 32'd0);
                chk("rst_instr", Instr, 32'd0);
                chk("rst_instr_pc", instr_pc, 32'd0);
                chk("rst_address", instr_address, RV);
                vprev = 1'b0; cprev = 1'b0; rwprev = 1'b0; hprev = 1'b0;
            end else begin
                if (hprev) begin
                    chk("halt_active", 32'(active), 32'd0);
                    chk("halt_read", 32'(instr_read), 32'd0);
                    chk("halt_valid", 32'(instr_valid), 32'd0);
                    chk("halt_address", instr_address, HA);
                end else begin
                    chk("active", 32'(active), 32'd1);
                end
                if (instr_read) begin
                    if (rwprev) chk("addr_held", instr_address, aprev);
                    if (!waitreq) begin
                        if (exp_addr_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL fetch_addr: unexpected read at %h", instr_address);
                        end else begin
                            chk("fetch_addr", instr_address, exp_addr_q.pop_front());
                        end
                    end
                end
                if (instr_valid && !vprev) begin
                    chk("valid_latency", 32'(cprev), 32'd1);
                    if (exp_instr_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL instr: unexpected valid word %h", Instr);
                    end else begin
                        e = exp_instr_q.pop_front();
                        chk("instr", Instr, e[63:32]);
                        chk("instr_pc", instr_pc, e[31:0]);
                    end
                    held_i  = Instr;
                    held_pc = instr_pc;
                end else if (instr_valid) begin
                    chk("instr_stable", Instr, held_i);
                    chk("instr_pc_stable", instr_pc, held_pc);
                end
                if (instr_valid) chk("no_read_while_valid", 32'(instr_read), 32'd0);
                rwprev = instr_read && waitreq;
                cprev  = instr_read && !waitreq;
                aprev  = instr_address;
                vprev  = instr_valid;
                hprev  = m_halted;
            end
        end
    end

    initial begin
        waitreq = 1'b0; readdata = '0; ready = 1'b0;
        ctrl = 2'd0; cond = 1'b0; rs = '0;
        rnd_mode = 1'b0; force_wait = 1'b0; dir_cond = 1'b0; prog = 1;

        // Taken BEQ with delay slot, then JR to the halt address.
        prog = 1; dir_cond = 1'b1;
        do_reset();
        run_to_halt();
        repeat (4) step();

        // Untaken BEQ, bus stall, held word under backpressure, J, JR halt.
        prog = 2; dir_cond = 1'b0;
        do_reset();
        run_to_halt();
        repeat (4) step();

        // Reset asserted while a read is stalled, then a clean rerun.
        prog = 1; dir_cond = 1'b1; force_wait = 1'b1;
        do_reset();
        repeat (3) step();
        #1 rst_n = 1'b0;
        force_wait = 1'b0;
        do_reset();
        run_to_halt();
        repeat (4) step();

        // Randomised control, stalls and backpressure.
        prog = 0; rnd_mode = 1'b1;
        do_reset();
        while (n_acc < 400 && !m_halted) step();
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
